// File: rtl/bb_header_parser_if.sv
// Bit-stream input and parsed-header/data-field output bundle for bb_header_parser.
// The master modport is the stream source and result consumer; the slave modport is the parser.
interface bb_header_parser_if #(
    parameter int LEN_W = 16
);
    logic             bit_stream_in;
    logic             valid_in;
    logic [LEN_W-1:0] K_BCH;
    logic             frame_start;
    logic             hdr_valid;
    logic             crc_ok;
    logic [15:0]      matype;
    logic [15:0]      upl;
    logic [15:0]      dfl;
    logic [7:0]       sync;
    logic [15:0]      syncd;
    logic             data_out;
    logic             data_valid;

    modport master (
        output bit_stream_in, valid_in, K_BCH,
        input  frame_start, hdr_valid, crc_ok, matype, upl, dfl, sync, syncd,
               data_out, data_valid
    );

    modport slave (
        input  bit_stream_in, valid_in, K_BCH,
        output frame_start, hdr_valid, crc_ok, matype, upl, dfl, sync, syncd,
               data_out, data_valid
    );
endinterface

// File: rtl/bb_header_parser.sv
// DVB-S2 BBHEADER parser: captures the 80-bit header, checks its CRC-8, forwards
// the DFL data-field bits and drops the padding up to the end of the K_BCH-bit frame.
module bb_header_parser #(
    parameter int         LEN_W    = 16,
    parameter logic [7:0] CRC_POLY = 8'hD5
) (
    input  logic                clk,
    input  logic                rst,
    bb_header_parser_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] HDR_LEN  = LEN_W'(80);
    localparam logic [LEN_W-1:0] CRC_BITS = LEN_W'(72);
    localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(79);

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    state_t           state_q;
    logic [LEN_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [7:0]       crc_q,       crc_d;
    logic [79:0]      shreg_q;
    logic [15:0]      data_cnt_q;
    logic             frame_start_q, hdr_valid_q, crc_ok_q, data_out_q, data_valid_q;
    logic [15:0]      matype_q, upl_q, dfl_q, syncd_q;
    logic [7:0]       sync_q;

    logic             first_bit_s, frame_end_s, hdr_last_s, rx_ok_s;
    logic [LEN_W-1:0] k_clamp_s;
    logic [7:0]       crc_base_s;
    logic [79:0]      hdr_word_s;

    // Frame position, clamped frame length and CRC progression for the bit on the input.
    always_comb begin
        first_bit_s = (bit_cnt_q == '0);
        k_clamp_s   = (bus.K_BCH < HDR_LEN) ? HDR_LEN : bus.K_BCH;
        frame_len_d = first_bit_s ? k_clamp_s : frame_len_q;
        frame_end_s = (bit_cnt_q == (frame_len_d - LEN_W'(1)));
        bit_cnt_d   = frame_end_s ? '0 : (bit_cnt_q + LEN_W'(1));
        crc_base_s  = first_bit_s ? 8'h00 : crc_q;
        crc_d       = (bit_cnt_q < CRC_BITS) ? crc8_step(crc_base_s, bus.bit_stream_in) : crc_q;
        hdr_word_s  = {shreg_q[78:0], bus.bit_stream_in};
        hdr_last_s  = (bit_cnt_q == HDR_LAST);
        // crc_q already covers bits 0..71 by the time bit 79 arrives
        rx_ok_s     = (crc_q == hdr_word_s[7:0]);
    end

    // Parser FSM with registered header fields, pulses and forwarded data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_HDR;
            bit_cnt_q     <= '0;
            frame_len_q   <= HDR_LEN;
            crc_q         <= 8'h00;
            shreg_q       <= 80'h0;
            data_cnt_q    <= 16'h0000;
            frame_start_q <= 1'b0;
            hdr_valid_q   <= 1'b0;
            crc_ok_q      <= 1'b0;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            matype_q      <= 16'h0000;
            upl_q         <= 16'h0000;
            dfl_q         <= 16'h0000;
            sync_q        <= 8'h00;
            syncd_q       <= 16'h0000;
        end else begin
            frame_start_q <= 1'b0;
            hdr_valid_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            if (bus.valid_in) begin
                bit_cnt_q     <= bit_cnt_d;
                frame_len_q   <= frame_len_d;
                crc_q         <= crc_d;
                frame_start_q <= first_bit_s;
                case (state_q)
                    ST_HDR: begin
                        shreg_q <= hdr_word_s;
                        if (hdr_last_s) begin
                            hdr_valid_q <= 1'b1;
                            matype_q    <= hdr_word_s[79:64];
                            upl_q       <= hdr_word_s[63:48];
                            dfl_q       <= hdr_word_s[47:32];
                            sync_q      <= hdr_word_s[31:24];
                            syncd_q     <= hdr_word_s[23:8];
                            crc_ok_q    <= rx_ok_s;
                            data_cnt_q  <= 16'h0000;
                            if (frame_end_s) begin
                                state_q <= ST_HDR;
                            end else if (rx_ok_s && (hdr_word_s[47:32] != 16'h0000)) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_PAD;
                            end
                        end else begin
                            state_q <= ST_HDR;
                        end
                    end
                    ST_DATA: begin
                        data_out_q   <= bus.bit_stream_in;
                        data_valid_q <= 1'b1;
                        data_cnt_q   <= data_cnt_q + 16'd1;
                        // frame end wins, which truncates an oversized DFL
                        if (frame_end_s) begin
                            state_q <= ST_HDR;
                        end else if ((data_cnt_q + 16'd1) == dfl_q) begin
                            state_q <= ST_PAD;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_PAD: begin
                        if (frame_end_s) begin
                            state_q <= ST_HDR;
                        end else begin
                            state_q <= ST_PAD;
                        end
                    end
                    default: begin
                        state_q <= ST_HDR;
                    end
                endcase
            end
        end
    end

    assign bus.frame_start = frame_start_q;
    assign bus.hdr_valid   = hdr_valid_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.matype      = matype_q;
    assign bus.upl         = upl_q;
    assign bus.dfl         = dfl_q;
    assign bus.sync        = sync_q;
    assign bus.syncd       = syncd_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
endmodule

// File: tb/tb_bb_header_parser.sv
// Randomized scoreboard bench for bb_header_parser: frames are built from field values,
// expected header records, data bits and frame-start positions are queued and checked by a monitor.
module tb_bb_header_parser;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bb_header_parser_if #(.LEN_W(16)) bus ();

    bb_header_parser #(.LEN_W(16), .CRC_POLY(8'hD5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] matype;
        logic [15:0] upl;
        logic [15:0] dfl;
        logic [7:0]  sync;
        logic [15:0] syncd;
        logic        crc_ok;
    } hdr_t;

    hdr_t hdr_q[$];
    logic data_q[$];
    int   fs_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   issued      = 0;
    int   mon_bits    = 0;

    logic fbits [0:1023];
    int   flen;

    // CRC-8 as the remainder of (message * x^8) divided by x^8+x^7+x^6+x^4+x^2+1
    function automatic logic [7:0] ref_crc(input logic [71:0] msg);
        logic [8:0]  rem;
        logic [79:0] aug;
        rem = 9'h000;
        aug = {msg, 8'h00};
        for (int i = 79; i >= 0; i--) begin
            rem = {rem[7:0], aug[i]};
            if (rem[8]) rem = rem ^ 9'h1D5;
        end
        return rem[7:0];
    endfunction

    // Build frame bits and queue the expected header record and forwarded bits
    task automatic build_frame(input logic [15:0] matype, input logic [15:0] upl,
                               input logic [15:0] dfl, input logic [7:0] sync,
                               input logic [15:0] syncd, input logic corrupt,
                               input int k, input logic expect_out);
        logic [71:0] h;
        logic [7:0]  c;
        logic [79:0] hw;
        hdr_t        e;
        int          nfwd;
        h  = {matype, upl, dfl, sync, syncd};
        c  = ref_crc(h);
        if (corrupt) c[0] = ~c[0];
        hw = {h, c};
        flen = (k < 80) ? 80 : k;
        for (int i = 0; i < 80; i++) fbits[i] = hw[79 - i];
        for (int i = 80; i < flen; i++) fbits[i] = 1'($urandom);
        fs_q.push_back(issued);
        if (expect_out) begin
            e.matype = matype; e.upl = upl; e.dfl = dfl;
            e.sync = sync; e.syncd = syncd;
            e.crc_ok = (c == ref_crc(h));
            hdr_q.push_back(e);
            nfwd = 0;
            if (e.crc_ok && dfl != 16'h0000) nfwd = (int'(dfl) < flen - 80) ? int'(dfl) : flen - 80;
            for (int j = 0; j < nfwd; j++) data_q.push_back(fbits[80 + j]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [76:0] outs;
        outs = {bus.frame_start, bus.hdr_valid, bus.crc_ok, bus.matype, bus.upl, bus.dfl,
                bus.sync, bus.syncd, bus.data_out, bus.data_valid};
        vectors++;
        if (outs !== 77'h0) begin
            miscompares++;
            $display("FAIL %s: outputs=%h required=0", name, outs);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_reset_outputs("reset_outputs");
            @(negedge clk);
        end
        rst = 1'b1;
    endtask

    // Send the built frame; K_BCH switches to k_mid halfway; abort_at>=0 resets before that bit
    task automatic send_frame(input int k_first, input int k_mid, input int gap_pct, input int abort_at);
        for (int i = 0; i < flen; i++) begin
            if (i == abort_at) begin
                do_reset(3);
                return;
            end
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                bus.valid_in      = 1'b0;
                bus.bit_stream_in = 1'($urandom);
            end
            @(negedge clk);
            bus.valid_in      = 1'b1;
            bus.bit_stream_in = fbits[i];
            bus.K_BCH         = 16'((i < flen / 2) ? k_first : k_mid);
            issued++;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.valid_in      = 1'b0;
            bus.bit_stream_in = 1'($urandom);
        end
    endtask

    // Monitor: sample just after each rising edge and compare against the queues
    initial begin
        logic vin;
        hdr_t got;
        hdr_t exp_h;
        logic exp_b;
        int   exp_i;
        forever begin
            @(posedge clk);
            vin = bus.valid_in && rst;
            #1;
            if (vin) mon_bits++;
            if (rst) begin
                if (bus.frame_start) begin
                    vectors++;
                    if (fs_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_start: unexpected pulse at bit %0d", mon_bits - 1);
                    end else begin
                        exp_i = fs_q.pop_front();
                        if (!vin || (mon_bits - 1) != exp_i) begin
                            miscompares++;
                            $display("FAIL frame_start: at bit %0d required bit %0d", mon_bits - 1, exp_i);
                        end
                    end
                end
                if (bus.hdr_valid) begin
                    vectors++;
                    got = {bus.matype, bus.upl, bus.dfl, bus.sync, bus.syncd, bus.crc_ok};
                    if (hdr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL header: unexpected hdr_valid, got %h", got);
                    end else begin
                        exp_h = hdr_q.pop_front();
                        if (got !== exp_h) begin
                            miscompares++;
                            $display("FAIL header: got %h required %h", got, exp_h);
                        end
                    end
                end
                if (bus.data_valid) begin
                    vectors++;
                    if (!vin) begin
                        miscompares++;
                        $display("FAIL data_gap: data_valid=1 after valid_in=0");
                    end else if (data_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL data: unexpected data bit %b", bus.data_out);
                    end else begin
                        exp_b = data_q.pop_front();
                        if (bus.data_out !== exp_b) begin
                            miscompares++;
                            $display("FAIL data: got %b required %b", bus.data_out, exp_b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int          k;
        logic [15:0] dfl;
        bus.valid_in      = 1'b0;
        bus.bit_stream_in = 1'b0;
        bus.K_BCH         = 16'd200;
        #1;
        check_reset_outputs("initial_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2);

        build_frame(16'h7200, 16'h0000, 16'd64, 8'h47, 16'h0000, 1'b0, 200, 1'b1);
        send_frame(200, 200, 0, -1);
        build_frame(16'h7200, 16'h0000, 16'd64, 8'h47, 16'h0000, 1'b1, 200, 1'b1);
        send_frame(200, 200, 0, -1);
        build_frame(16'h7200, 16'h0000, 16'd64, 8'h47, 16'h0000, 1'b0, 200, 1'b1);
        send_frame(200, 200, 0, -1);
        build_frame(16'h1234, 16'h0BC0, 16'd500, 8'h47, 16'h0010, 1'b0, 200, 1'b1);
        send_frame(200, 200, 0, -1);
        build_frame(16'h7200, 16'h0000, 16'd64, 8'h47, 16'h0000, 1'b0, 200, 1'b1);
        send_frame(200, 200, 30, -1);
        build_frame(16'hA5A5, 16'h0001, 16'd32, 8'hB8, 16'h0002, 1'b0, 200, 1'b0);
        send_frame(200, 200, 0, 40);
        build_frame(16'h7200, 16'h00BC, 16'd100, 8'h47, 16'h0008, 1'b0, 200, 1'b1);
        send_frame(200, 200, 0, -1);
        build_frame(16'h4200, 16'h0000, 16'd150, 8'h47, 16'h0000, 1'b0, 200, 1'b1);
        send_frame(200, 300, 0, -1);
        build_frame(16'h4200, 16'h0000, 16'd150, 8'h47, 16'h0000, 1'b0, 300, 1'b1);
        send_frame(300, 300, 0, -1);
        build_frame(16'h0F0F, 16'h0000, 16'd0, 8'h47, 16'h0000, 1'b0, 120, 1'b1);
        send_frame(120, 120, 0, -1);

        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(3))
                0:       k = int'($urandom_range(40, 80));
                1:       k = 80;
                2:       k = int'($urandom_range(81, 160));
                default: k = int'($urandom_range(161, 320));
            endcase
            dfl = ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom_range(1, 300));
            build_frame(16'($urandom), 16'($urandom), dfl, 8'($urandom), 16'($urandom),
                        ($urandom_range(3) == 0), k, 1'b1);
            send_frame(k, int'($urandom_range(0, 400)), ($urandom_range(1) == 0) ? 0 : 20, -1);
        end
        idle(20);

        vectors++;
        if (hdr_q.size() != 0) begin
            miscompares++;
            $display("FAIL hdr_drain: %0d headers left, required 0", hdr_q.size());
        end
        vectors++;
        if (data_q.size() != 0) begin
            miscompares++;
            $display("FAIL data_drain: %0d data bits left, required 0", data_q.size());
        end
        vectors++;
        if (fs_q.size() != 0) begin
            miscompares++;
            $display("FAIL fs_drain: %0d frame starts left, required 0", fs_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
